systolic_sched: RTL and testbench

SYSTOLIC_SCHED -- requirements
Module: systolic_sched

---
 rtl/systolic_sched_if.sv | 34 +++
 rtl/systolic_sched.sv | 152 +++++++++++++++
 tb/tb_systolic_sched.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_sched_if.sv
// rtl/systolic_sched_if.sv - job, systolic-array and response signals of the systolic scheduler
interface systolic_sched_if #(
    parameter int W = 32,
    parameter int N = 3
);
    logic               i_req_valid;
    logic               o_req_ready;
    logic               i_mode;
    logic [W*N*N-1:0]   i_A;
    logic [W*N*N-1:0]   i_B;
    logic               o_sa_en;
    logic               o_sa_clr;
    logic               o_sa_mode;
    logic [W*N-1:0]     o_A_row;
    logic [W*N-1:0]     o_B_col;
    logic [W*N*N-1:0]   i_sa_C;
    logic               o_rsp_valid;
    logic               i_rsp_ready;
    logic [W*N*N-1:0]   o_C;
    logic               o_busy;
    logic [15:0]        o_jobs;

    modport master (
        output i_req_valid, i_mode, i_A, i_B, i_sa_C, i_rsp_ready,
        input  o_req_ready, o_sa_en, o_sa_clr, o_sa_mode, o_A_row, o_B_col,
               o_rsp_valid, o_C, o_busy, o_jobs
    );

    modport slave (
        input  i_req_valid, i_mode, i_A, i_B, i_sa_C, i_rsp_ready,
        output o_req_ready, o_sa_en, o_sa_clr, o_sa_mode, o_A_row, o_B_col,
               o_rsp_valid, o_C, o_busy, o_jobs
    );
endinterface

// File: rtl/systolic_sched.sv
// rtl/systolic_sched.sv - job scheduler feeding skewed A/B lanes into an N x N systolic array
module systolic_sched #(
    parameter int W = 32,
    parameter int N = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    systolic_sched_if.slave  bus
);
    localparam int CW = $clog2(2 * N);
    localparam logic [CW-1:0] FEED_LAST  = CW'(2 * N - 2);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [W*N*N-1:0]   a_q, b_q, c_q;
    logic               mode_q;
    logic [15:0]        jobs_q;
    logic [W*N-1:0]     a_row_q, b_col_q, a_row_d, b_col_d;
    logic               req_ready, sa_en, sa_clr, busy, rsp_valid;
    logic               accept, feed_last, drain_last, rsp_done;

    // Lane i carries A[i][t-i]; zero outside the diagonal band.
    function automatic logic [W*N-1:0] skew_a(input logic [W*N*N-1:0] m, input int t);
        logic [W*N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) begin
            if (t - i >= 0 && t - i < N) v[i*W +: W] = m[(i*N + (t - i))*W +: W];
        end
        return v;
    endfunction

    function automatic logic [W*N-1:0] skew_b(input logic [W*N*N-1:0] m, input int t);
        logic [W*N-1:0] v;
        v = '0;
        for (int j = 0; j < N; j++) begin
            if (t - j >= 0 && t - j < N) v[j*W +: W] = m[((t - j)*N + j)*W +: W];
        end
        return v;
    endfunction

    assign accept     = bus.i_req_valid && req_ready;
    assign feed_last  = (cnt_q == FEED_LAST);
    assign drain_last = (cnt_q == DRAIN_LAST);
    assign rsp_done   = (state_q == S_DONE) && bus.i_rsp_ready;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        sa_en     = 1'b0;
        sa_clr    = 1'b0;
        busy      = 1'b1;
        rsp_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (bus.i_req_valid) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                sa_en   = 1'b1;
                sa_clr  = 1'b1;
                state_d = S_FEED;
            end
            S_FEED: begin
                sa_en = 1'b1;
                if (feed_last) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                sa_en = 1'b1;
                if (drain_last) state_d = S_DONE;
            end
            S_DONE: begin
                rsp_valid = 1'b1;
                if (bus.i_rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Lane registers are loaded one cycle ahead so they present FEED cycle t while cnt_q == t.
    always_comb begin
        a_row_d = '0;
        b_col_d = '0;
        cnt_d   = '0;
        case (state_q)
            S_CLEAR: begin
                a_row_d = skew_a(a_q, 0);
                b_col_d = skew_b(b_q, 0);
            end
            S_FEED: begin
                if (!feed_last) begin
                    a_row_d = skew_a(a_q, int'(cnt_q) + 1);
                    b_col_d = skew_b(b_q, int'(cnt_q) + 1);
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (!drain_last) cnt_d = cnt_q + 1'b1;
            end
            default: cnt_d = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            mode_q  <= 1'b0;
            jobs_q  <= '0;
            cnt_q   <= '0;
            a_row_q <= '0;
            b_col_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            a_row_q <= a_row_d;
            b_col_q <= b_col_d;
            if (accept) begin
                a_q    <= bus.i_A;
                b_q    <= bus.i_B;
                mode_q <= bus.i_mode;
            end
            if (state_q == S_DRAIN && drain_last) c_q <= bus.i_sa_C;
            if (rsp_done) jobs_q <= jobs_q + 16'd1;
        end
    end

    assign bus.o_req_ready = req_ready;
    assign bus.o_sa_en     = sa_en;
    assign bus.o_sa_clr    = sa_clr;
    assign bus.o_sa_mode   = mode_q;
    assign bus.o_A_row     = a_row_q;
    assign bus.o_B_col     = b_col_q;
    assign bus.o_rsp_valid = rsp_valid;
    assign bus.o_C         = c_q;
    assign bus.o_busy      = busy;
    assign bus.o_jobs      = jobs_q;
endmodule

// File: tb/tb_systolic_sched.sv
// tb/tb_systolic_sched.sv - self-checking bench for systolic_sched against a lane/latency model
module tb_systolic_sched;
    localparam int W  = 32;
    localparam int N  = 3;
    localparam int CB = W * N * N;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    systolic_sched_if #(.W(W), .N(N)) sif ();
    systolic_sched #(.W(W), .N(N)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (sif)
    );

    int          checks = 0;
    int          errors = 0;
    int          ma[N][N], mb[N][N], na[N][N], nb[N][N];
    logic        mmode, nmode;
    logic [15:0] exp_jobs;

    task automatic chk(input string tag, input logic [CB-1:0] obs, input logic [CB-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CB-1:0] pack(input int m[N][N]);
        logic [CB-1:0] v;
        v = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) v[(r*N + c)*W +: W] = m[r][c];
        return v;
    endfunction

    function automatic logic [CB-1:0] rand_bus();
        logic [CB-1:0] v;
        for (int k = 0; k < N * N; k++) v[k*W +: W] = $urandom;
        return v;
    endfunction

    function automatic logic [W*N-1:0] lane_a(input int t);
        logic [W*N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++)
            if (t - i >= 0 && t - i < N) v[i*W +: W] = ma[i][t - i];
        return v;
    endfunction

    function automatic logic [W*N-1:0] lane_b(input int t);
        logic [W*N-1:0] v;
        v = '0;
        for (int j = 0; j < N; j++)
            if (t - j >= 0 && t - j < N) v[j*W +: W] = mb[t - j][j];
        return v;
    endfunction

    // Presents a request at a negedge in IDLE; returns just after the accept edge.
    task automatic begin_job(input bit directed);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ma[r][c] = directed ? 10*r + c + 1   : int'($urandom);
                mb[r][c] = directed ? 100 + 10*r + c : int'($urandom);
            end
        mmode = 1'($urandom_range(0, 1));
        sif.i_A = pack(ma);
        sif.i_B = pack(mb);
        sif.i_mode = mmode;
        sif.i_req_valid = 1'b1;
        chk("req_ready_idle", CB'(sif.o_req_ready), CB'(1));
        @(posedge clk);
    endtask

    // Follows an accepted job through CLEAR/FEED/DRAIN/DONE and the response handshake.
    task automatic follow_job(input int hold, input bit busy_req);
        logic [CB-1:0] k;
        k = rand_bus();
        sif.i_sa_C = k;
        @(negedge clk);
        sif.i_req_valid = busy_req;
        if (busy_req) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) begin
                    na[r][c] = int'($urandom);
                    nb[r][c] = int'($urandom);
                end
            nmode = ~mmode;
            sif.i_A = pack(na);
            sif.i_B = pack(nb);
            sif.i_mode = nmode;
        end else begin
            sif.i_A = rand_bus();
            sif.i_B = rand_bus();
            sif.i_mode = ~mmode;
        end
        chk("clear_clr", CB'(sif.o_sa_clr), CB'(1));
        chk("clear_en", CB'(sif.o_sa_en), CB'(1));
        chk("clear_busy", CB'(sif.o_busy), CB'(1));
        chk("clear_ready", CB'(sif.o_req_ready), CB'(0));
        chk("clear_arow", CB'(sif.o_A_row), CB'(0));
        for (int t = 0; t < 2*N - 1; t++) begin
            @(negedge clk);
            chk($sformatf("feed%0d_arow", t), CB'(sif.o_A_row), CB'(lane_a(t)));
            chk($sformatf("feed%0d_bcol", t), CB'(sif.o_B_col), CB'(lane_b(t)));
            chk("feed_en", CB'(sif.o_sa_en), CB'(1));
            chk("feed_clr", CB'(sif.o_sa_clr), CB'(0));
            chk("feed_ready", CB'(sif.o_req_ready), CB'(0));
            chk("feed_mode", CB'(sif.o_sa_mode), CB'(mmode));
            sif.i_rsp_ready = 1'($urandom_range(0, 1));
        end
        for (int d = 0; d < N; d++) begin
            @(negedge clk);
            chk("drain_en", CB'(sif.o_sa_en), CB'(1));
            chk("drain_arow", CB'(sif.o_A_row), CB'(0));
            chk("drain_bcol", CB'(sif.o_B_col), CB'(0));
            chk("drain_rsp_valid", CB'(sif.o_rsp_valid), CB'(0));
            if (d == N - 1) sif.i_rsp_ready = 1'b0;
        end
        @(negedge clk);
        chk("done_rsp_valid", CB'(sif.o_rsp_valid), CB'(1));
        chk("done_c", sif.o_C, k);
        chk("done_en", CB'(sif.o_sa_en), CB'(0));
        chk("done_busy", CB'(sif.o_busy), CB'(1));
        for (int h = 0; h < hold; h++) begin
            sif.i_sa_C = rand_bus();
            @(negedge clk);
            chk("hold_rsp_valid", CB'(sif.o_rsp_valid), CB'(1));
            chk("hold_c", sif.o_C, k);
            chk("hold_jobs", CB'(sif.o_jobs), CB'(exp_jobs));
        end
        sif.i_rsp_ready = 1'b1;
        @(negedge clk);
        sif.i_rsp_ready = 1'b0;
        exp_jobs = exp_jobs + 16'd1;
        chk("post_jobs", CB'(sif.o_jobs), CB'(exp_jobs));
        chk("post_rsp_valid", CB'(sif.o_rsp_valid), CB'(0));
        chk("post_ready", CB'(sif.o_req_ready), CB'(1));
        chk("post_busy", CB'(sif.o_busy), CB'(0));
    endtask

    initial begin
        sif.i_req_valid = 1'b0;
        sif.i_mode      = 1'b0;
        sif.i_A         = '0;
        sif.i_B         = '0;
        sif.i_sa_C      = '0;
        sif.i_rsp_ready = 1'b0;
        exp_jobs        = 16'd0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", CB'(sif.o_busy), CB'(0));
        chk("rst_en", CB'(sif.o_sa_en), CB'(0));
        chk("rst_rsp_valid", CB'(sif.o_rsp_valid), CB'(0));
        chk("rst_jobs", CB'(sif.o_jobs), CB'(0));
        chk("rst_c", sif.o_C, '0);
        chk("rst_arow", CB'(sif.o_A_row), CB'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_release_ready", CB'(sif.o_req_ready), CB'(1));

        // Reset at FEED t=2 discards the job
        begin_job(1'b0);
        sif.i_sa_C = rand_bus();
        @(negedge clk);
        sif.i_req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("midfeed_arow", CB'(sif.o_A_row), CB'(lane_a(2)));
        rst_n = 1'b0;
        @(negedge clk);
        exp_jobs = 16'd0;
        chk("midrst_en", CB'(sif.o_sa_en), CB'(0));
        chk("midrst_arow", CB'(sif.o_A_row), CB'(0));
        chk("midrst_bcol", CB'(sif.o_B_col), CB'(0));
        chk("midrst_busy", CB'(sif.o_busy), CB'(0));
        chk("midrst_mode", CB'(sif.o_sa_mode), CB'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_ready", CB'(sif.o_req_ready), CB'(1));
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("midrst_no_rsp", CB'(sif.o_rsp_valid), CB'(0));
            chk("midrst_jobs", CB'(sif.o_jobs), CB'(exp_jobs));
        end

        // Directed lane skew pattern
        begin_job(1'b1);
        follow_job(0, 1'b0);

        // Random jobs with short backpressure
        for (int j = 0; j < 6; j++) begin
            begin_job(1'b0);
            follow_job(int'($urandom_range(0, 4)), 1'b0);
        end

        // 20-cycle backpressure in DONE
        begin_job(1'b0);
        follow_job(20, 1'b0);

        // Request held during a job is taken on the first IDLE cycle
        begin_job(1'b0);
        follow_job(2, 1'b1);
        ma = na;
        mb = nb;
        mmode = nmode;
        @(posedge clk);
        follow_job(1, 1'b0);

        // Job counter wrap
        @(negedge clk);
        force dut.jobs_q = 16'hFFFF;
        @(negedge clk);
        release dut.jobs_q;
        exp_jobs = 16'hFFFF;
        chk("wrap_preload", CB'(sif.o_jobs), CB'(exp_jobs));
        begin_job(1'b0);
        follow_job(0, 1'b0);
        chk("wrap_zero", CB'(sif.o_jobs), CB'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
